// File: rtl/acc_2p_block_pkg.sv
// Shared types, defaults and helpers for the block-sum accumulator.
package acc_2p_block_pkg;

    localparam int unsigned DEF_WIDTH     = 15;
    localparam int unsigned DEF_BLOCK_LEN = 16;
    localparam int unsigned DEF_AW1       = 9;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        FLUSH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Ceiling log2; clog2(1) = 0, clog2(16) = 4, clog2(17) = 5.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned t;
        r = 0;
        t = (v > 0) ? v - 1 : 0;
        while (t > 0) begin
            r = r + 1;
            t = t >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/acc_2p_block_split_acc_cell.sv
// One half of the split accumulator: N-bit register fed by an adder with carry in/out.
module acc_2p_block_split_acc_cell #(
    parameter int unsigned N = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic [N-1:0] addend,
    input  logic         cin,
    output logic [N-1:0] q,
    output logic         cout_c
);

    logic [N:0] sum_c;

    // Carry out of this half is exposed combinationally; the parent registers it.
    assign sum_c  = {1'b0, q} + {1'b0, addend} + (N+1)'(cin);
    assign cout_c = sum_c[N];

    // Accumulate every cycle; a take clears the half for the next block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else begin
            q <= sum_c[N-1:0];
        end
    end

endmodule

// File: rtl/acc_2p_block.sv
// Block-sum accumulator on the adder result stream: BLOCK_LEN samples per output,
// split LSB/MSB arithmetic with a registered carry between the halves.
module acc_2p_block
    import acc_2p_block_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned BLOCK_LEN = DEF_BLOCK_LEN,
    parameter int unsigned AWIDTH    = WIDTH + clog2(BLOCK_LEN),
    parameter int unsigned AW1       = DEF_AW1,
    parameter int unsigned AW2       = AWIDTH - AW1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [AWIDTH-1:0] out_data,
    input  logic              out_ready,
    output logic              out_ovf
);

    localparam int unsigned CW = clog2(BLOCK_LEN);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            c_reg;
    logic            ovf;

    logic            accept_c;
    logic            take_c;
    logic [AWIDTH-1:0] x_c;
    logic [AW1-1:0]  lsb_add_c;
    logic [AW2-1:0]  msb_add_c;
    logic            msb_cin_c;
    logic [AW1-1:0]  lsb_q;
    logic [AW2-1:0]  msb_q;
    logic            lsb_cout_c;
    logic            msb_cout_c;

    assign accept_c = in_valid & in_ready;
    assign take_c   = out_valid & out_ready;
    assign x_c      = AWIDTH'(in_data);

    // Select what each half adds this cycle; the pending carry folds even when idle.
    always_comb begin
        lsb_add_c = '0;
        msb_add_c = '0;
        msb_cin_c = 1'b0;
        case (state)
            ACCUM: begin
                msb_cin_c = c_reg;
                if (accept_c) begin
                    lsb_add_c = x_c[AW1-1:0];
                    msb_add_c = x_c[AWIDTH-1:AW1];
                end
            end
            FLUSH: begin
                msb_cin_c = c_reg;
            end
            default: begin
            end
        endcase
    end

    acc_2p_block_split_acc_cell #(.N(AW1)) u_lsb (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (take_c),
        .addend (lsb_add_c),
        .cin    (1'b0),
        .q      (lsb_q),
        .cout_c (lsb_cout_c)
    );

    acc_2p_block_split_acc_cell #(.N(AW2)) u_msb (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (take_c),
        .addend (msb_add_c),
        .cin    (msb_cin_c),
        .q      (msb_q),
        .cout_c (msb_cout_c)
    );

    assign out_data = {msb_q, lsb_q};
    assign out_ovf  = ovf;

    // Block FSM with sample count, inter-half carry, sticky overflow and handshake flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACCUM;
            cnt       <= '0;
            c_reg     <= 1'b0;
            ovf       <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    c_reg <= lsb_cout_c;
                    ovf   <= ovf | msb_cout_c;
                    if (accept_c) begin
                        if (cnt == CW'(BLOCK_LEN - 1)) begin
                            state    <= FLUSH;
                            in_ready <= 1'b0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                FLUSH: begin
                    c_reg     <= 1'b0;
                    ovf       <= ovf | msb_cout_c;
                    state     <= HOLD;
                    out_valid <= 1'b1;
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= ACCUM;
                        cnt       <= '0;
                        c_reg     <= 1'b0;
                        ovf       <= 1'b0;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= ACCUM;
                    cnt       <= '0;
                    c_reg     <= 1'b0;
                    ovf       <= 1'b0;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_acc_2p_block.sv
// Directed bench for acc_2p_block: default instance plus a narrow 16-bit instance
// sharing the same stimulus, so the wrap case runs alongside the normal ones.
module tb_acc_2p_block;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [14:0] in_data;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [18:0] out_data;
    logic        out_ovf;

    logic        b_in_ready;
    logic        b_out_valid;
    logic [15:0] b_out_data;
    logic        b_out_ovf;

    int checks;
    int errors;

    acc_2p_block dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .out_ovf   (out_ovf)
    );

    acc_2p_block #(
        .WIDTH(15), .BLOCK_LEN(16), .AWIDTH(16), .AW1(8), .AW2(8)
    ) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (b_in_ready),
        .out_valid (b_out_valid),
        .out_data  (b_out_data),
        .out_ready (out_ready),
        .out_ovf   (b_out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One accepted sample per call; called at a falling edge, returns at the next.
    task automatic push(input logic [14:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
    endtask

    task automatic push_n(input int n, input logic [14:0] d);
        for (int i = 0; i < n; i++) push(d);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_data !== 19'd0) begin errors++; $display("FAIL reset_out_data got %0d want 0", out_data); end
        checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL reset_out_ovf got %b want 0", out_ovf); end
        checks++; if (b_in_ready !== 1'b1 || b_out_data !== 16'd0) begin errors++; $display("FAIL reset_b got rdy=%b data=%0d want rdy=1 data=0", b_in_ready, b_out_data); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ramp();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ramp_start_ready got %b want 1", in_ready); end
        for (int i = 1; i <= 16; i++) push(15'(i));
        in_valid = 1'b0;
        // one cycle after the last accept: flush, nothing visible yet
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ramp_flush_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ramp_flush_ready got %b want 0", in_ready); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ramp_latency_valid got %b want 1", out_valid); end
        checks++; if (out_data !== 19'd136) begin errors++; $display("FAIL ramp_sum got %0d want 136", out_data); end
        checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL ramp_ovf got %b want 0", out_ovf); end
        checks++; if (b_out_data !== 16'd136) begin errors++; $display("FAIL ramp_sum_b got %0d want 136", b_out_data); end
        @(negedge clk);
        // taken on the single HOLD cycle: 18-cycle block period
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL ramp_after_take got valid=%b ready=%b want valid=0 ready=1", out_valid, in_ready); end
        checks++; if (out_data !== 19'd0) begin errors++; $display("FAIL ramp_cleared got %0d want 0", out_data); end
    endtask

    task automatic test_lsb_carry();
        push_n(16, 15'd511);
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_data !== 19'd8176) begin errors++; $display("FAIL lsb_carry_sum got valid=%b data=%0d want valid=1 data=8176", out_valid, out_data); end
        checks++; if (b_out_data !== 16'd8176) begin errors++; $display("FAIL lsb_carry_sum_b got %0d want 8176", b_out_data); end
        @(negedge clk);
    endtask

    task automatic test_max_and_wrap();
        push_n(16, 15'd32767);
        @(negedge clk);
        checks++; if (out_data !== 19'd524272) begin errors++; $display("FAIL max_sum got %0d want 524272", out_data); end
        checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL max_ovf got %b want 0", out_ovf); end
        checks++; if (b_out_valid !== 1'b1 || b_out_data !== 16'd65520) begin errors++; $display("FAIL wrap_sum got valid=%b data=%0d want valid=1 data=65520", b_out_valid, b_out_data); end
        checks++; if (b_out_ovf !== 1'b1) begin errors++; $display("FAIL wrap_ovf got %b want 1", b_out_ovf); end
        @(negedge clk);
        checks++; if (b_out_ovf !== 1'b0) begin errors++; $display("FAIL wrap_ovf_clear got %b want 0", b_out_ovf); end
    endtask

    task automatic test_hold_stall();
        out_ready = 1'b0;
        push_n(16, 15'd3);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_data  = 15'd7;
            checks++; if (out_valid !== 1'b1 || out_data !== 19'd48) begin errors++; $display("FAIL stall_hold[%0d] got valid=%b data=%0d want valid=1 data=48", k, out_valid, out_data); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready[%0d] got %b want 0", k, in_ready); end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready got %b want 1", in_ready); end
        push_n(16, 15'd1);
        @(negedge clk);
        checks++; if (out_data !== 19'd16) begin errors++; $display("FAIL stall_next_block got %0d want 16", out_data); end
        @(negedge clk);
    endtask

    task automatic test_gaps();
        for (int i = 0; i < 16; i++) begin
            push(15'd5);
            if (i < 15) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL gaps_early_valid got %b want 0", out_valid); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_data !== 19'd80) begin errors++; $display("FAIL gaps_sum got valid=%b data=%0d want valid=1 data=80", out_valid, out_data); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        push_n(8, 15'd100);
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (out_data !== 19'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL midreset_state got data=%0d ready=%b want data=0 ready=1", out_data, in_ready); end
        rst_n = 1'b1;
        @(negedge clk);
        push_n(16, 15'd2);
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_data !== 19'd32) begin errors++; $display("FAIL midreset_sum got valid=%b data=%0d want valid=1 data=32", out_valid, out_data); end
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_ramp();
        test_lsb_carry();
        test_max_and_wrap();
        test_hold_stall();
        test_gaps();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
